// File: rtl/operand_loader.sv
// Operand front end for the 2-bit ripple adder: synchronises switches and buttons,
// debounces the buttons and sequences operand loading through a three-state FSM.
module operand_loader #(
   parameter  int DEBOUNCE_CYCLES = 100000,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] sw,
   input  logic       btn_load,
   input  logic       btn_clear,
   output logic [1:0] test1,
   output logic [1:0] test2,
   output logic       operands_valid,
   output logic [1:0] state_led
);

   typedef enum logic [1:0] {
      LOAD_A = 2'b00,
      LOAD_B = 2'b01,
      READY  = 2'b10
   } state_t;

   logic [1:0] sw_meta_reg;
   logic [1:0] sw_sync_reg;
   logic [1:0] btn_raw;
   logic [1:0] pulse;
   logic       load_p;
   logic       clear_p;

   state_t     state_reg,  state_next;
   logic [1:0] test1_reg,  test1_next;
   logic [1:0] test2_reg,  test2_next;
   logic       valid_reg,  valid_next;

   assign btn_raw = {btn_clear, btn_load};

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_meta_reg <= 2'b00;
         sw_sync_reg <= 2'b00;
      end else begin
         sw_meta_reg <= sw;
         sw_sync_reg <= sw_meta_reg;
      end
   end

   // Index 0 is the load button, index 1 the clear button.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         logic             meta_reg;
         logic             sync_reg;
         logic             deb_reg;
         logic             deb_prev_reg;
         logic [CNT_W-1:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               meta_reg     <= 1'b0;
               sync_reg     <= 1'b0;
               deb_reg      <= 1'b0;
               deb_prev_reg <= 1'b0;
               cnt_reg      <= '0;
            end else begin
               meta_reg     <= btn_raw[gi];
               sync_reg     <= meta_reg;
               deb_prev_reg <= deb_reg;
               if (sync_reg == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  // Mismatch has persisted for DEBOUNCE_CYCLES samples: accept it.
                  deb_reg <= sync_reg;
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
         end

         assign pulse[gi] = deb_reg & ~deb_prev_reg;
      end
   endgenerate

   assign load_p  = pulse[0];
   assign clear_p = pulse[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= LOAD_A;
         test1_reg <= 2'b00;
         test2_reg <= 2'b00;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         test1_reg <= test1_next;
         test2_reg <= test2_next;
         valid_reg <= valid_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      test1_next = test1_reg;
      test2_next = test2_reg;
      if (clear_p) begin
         state_next = LOAD_A;
         test1_next = 2'b00;
         test2_next = 2'b00;
      end else if (load_p) begin
         case (state_reg)
            LOAD_A: begin
               test1_next = sw_sync_reg;
               state_next = LOAD_B;
            end
            LOAD_B: begin
               test2_next = sw_sync_reg;
               state_next = READY;
            end
            READY: begin
               test1_next = sw_sync_reg;
               state_next = LOAD_B;
            end
            default: state_next = LOAD_A;
         endcase
      end
      valid_next = (state_next == READY);
   end

   assign test1          = test1_reg;
   assign test2          = test2_reg;
   assign operands_valid = valid_reg;
   assign state_led      = state_reg;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader with a short debounce window and a
// window-based behavioural model of debounce, edge detection and loading.
module tb_operand_loader;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] sw = 2'b00;
   logic       btn_load = 1'b0;
   logic       btn_clear = 1'b0;
   logic [1:0] test1;
   logic [1:0] test2;
   logic       operands_valid;
   logic [1:0] state_led;

   int checks = 0;
   int errors = 0;

   operand_loader #(.DEBOUNCE_CYCLES(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .sw             (sw),
      .btn_load       (btn_load),
      .btn_clear      (btn_clear),
      .test1          (test1),
      .test2          (test2),
      .operands_valid (operands_valid),
      .state_led      (state_led)
   );

   always #5 clk = ~clk;

   // Reference model: a button level is accepted once the last N synchronised
   // samples all disagree with the current accepted level; a rising acceptance
   // acts on the operand registers at the following edge.
   logic [1:0] m_s1_sw, m_s2_sw;
   logic       m_s1 [2];
   logic       m_s2 [2];
   logic       m_deb [2];
   logic       m_pend [2];
   logic       m_win [2][N];
   logic [1:0] m_t1, m_t2, m_state;

   task automatic model_step();
      logic all_diff;
      if (rst) begin
         m_s1_sw = 0; m_s2_sw = 0; m_t1 = 0; m_t2 = 0; m_state = 0;
         for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_pend[b] = 0;
            for (int i = 0; i < N; i++) m_win[b][i] = 0;
         end
      end else begin
         if (m_pend[1]) begin
            m_t1 = 0; m_t2 = 0; m_state = 0;
         end else if (m_pend[0]) begin
            if (m_state == 0)      begin m_t1 = m_s2_sw; m_state = 1; end
            else if (m_state == 1) begin m_t2 = m_s2_sw; m_state = 2; end
            else                   begin m_t1 = m_s2_sw; m_state = 1; end
         end
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N - 1; i++) m_win[b][i] = m_win[b][i+1];
            m_win[b][N-1] = m_s2[b];
            all_diff = 1'b1;
            for (int i = 0; i < N; i++) if (m_win[b][i] == m_deb[b]) all_diff = 1'b0;
            m_pend[b] = 1'b0;
            if (all_diff) begin
               m_deb[b]  = ~m_deb[b];
               m_pend[b] = m_deb[b];
            end
         end
         m_s2_sw = m_s1_sw; m_s1_sw = sw;
         m_s2[0] = m_s1[0]; m_s1[0] = btn_load;
         m_s2[1] = m_s1[1]; m_s1[1] = btn_clear;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; btn_load = 0; btn_clear = 0;
      ticks(2);
      rst = 1'b0;
   endtask

   task automatic press_load(input logic [1:0] val, input int hold);
      sw = val; btn_load = 1'b1;
      ticks(hold);
      btn_load = 1'b0;
      ticks(N + 4);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sw = 2'($urandom_range(3)); btn_load = 1'($urandom_range(1)); btn_clear = 1'($urandom_range(1));
      ticks(3);
      checks++;
      if ({test1, test2, operands_valid, state_led} !== 7'b0)
         $display("FAIL reset_outputs got t1=%b t2=%b v=%b st=%b want all zero",
                  test1, test2, operands_valid, state_led);
      if ({test1, test2, operands_valid, state_led} !== 7'b0) errors++;
      rst = 1'b0; btn_load = 0; btn_clear = 0;
      ticks(N + 4);
      $display("test_reset done");
   endtask

   task automatic test_load_sequence();
      logic [1:0] a, b;
      int lat;
      a = 2'($urandom_range(3)); b = 2'($urandom_range(3));
      do_reset();
      sw = a; btn_load = 1'b1;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (lat == 0 && state_led == 2'b01) lat = k;
      end
      btn_load = 1'b0;
      ticks(N + 4);
      checks++;
      if (lat != N + 3) begin
         errors++;
         $display("FAIL first_press_latency got %0d want %0d", lat, N + 3);
      end
      checks++;
      if (test1 !== a || state_led !== 2'b01 || operands_valid !== 1'b0) begin
         errors++;
         $display("FAIL load_a got t1=%b st=%b v=%b want t1=%b st=01 v=0",
                  test1, state_led, operands_valid, a);
      end
      press_load(b, 6);
      checks++;
      if (test1 !== a || test2 !== b || operands_valid !== 1'b1 || state_led !== 2'b10) begin
         errors++;
         $display("FAIL load_b got t1=%b t2=%b v=%b st=%b want t1=%b t2=%b v=1 st=10",
                  test1, test2, operands_valid, state_led, a, b);
      end
      $display("test_load_sequence a=%b b=%b latency=%0d", a, b, lat);
   endtask

   task automatic test_bounce();
      int bad;
      do_reset();
      sw = 2'($urandom_range(1, 3));
      bad = 0;
      for (int r = 0; r < 5; r++) begin
         btn_load = 1'b1; ticks(N - 1);
         btn_load = 1'b0; tick();
         if (test1 !== 2'b00 || state_led !== 2'b00) bad++;
      end
      ticks(N + 4);
      checks++;
      if (bad != 0 || test1 !== 2'b00 || state_led !== 2'b00) begin
         errors++;
         $display("FAIL bounce_rejected got t1=%b st=%b bad=%0d want t1=00 st=00",
                  test1, state_led, bad);
      end
      $display("test_bounce done");
   endtask

   task automatic test_ready_reload();
      logic [1:0] c;
      do_reset();
      press_load(2'b11, 10);
      press_load(2'b01, 10);
      c = 2'($urandom_range(3));
      press_load(c, 5);
      checks++;
      if (test1 !== c || test2 !== 2'b01 || operands_valid !== 1'b0 || state_led !== 2'b01) begin
         errors++;
         $display("FAIL ready_reload got t1=%b t2=%b v=%b st=%b want t1=%b t2=01 v=0 st=01",
                  test1, test2, operands_valid, state_led, c);
      end
      $display("test_ready_reload c=%b", c);
   endtask

   task automatic test_clear_priority();
      logic [1:0] d;
      do_reset();
      press_load(2'b10, 6);
      sw = 2'b11; btn_load = 1'b1; btn_clear = 1'b1;
      ticks(10);
      btn_load = 1'b0; btn_clear = 1'b0;
      ticks(N + 4);
      checks++;
      if (test1 !== 2'b00 || test2 !== 2'b00 || state_led !== 2'b00 || operands_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear_priority got t1=%b t2=%b st=%b v=%b want all zero",
                  test1, test2, state_led, operands_valid);
      end
      d = 2'($urandom_range(1, 3));
      press_load(d, 7);
      checks++;
      if (test1 !== d || state_led !== 2'b01) begin
         errors++;
         $display("FAIL load_after_clear got t1=%b st=%b want t1=%b st=01", test1, state_led, d);
      end
      $display("test_clear_priority d=%b", d);
   endtask

   task automatic test_long_hold();
      logic [1:0] a;
      logic [1:0] prev_st;
      int changes;
      do_reset();
      a = 2'($urandom_range(3));
      sw = a; btn_load = 1'b1;
      changes = 0; prev_st = state_led;
      for (int k = 1; k <= 50; k++) begin
         if (k > 10) sw = 2'($urandom_range(3));
         tick();
         if (state_led !== prev_st) changes++;
         prev_st = state_led;
      end
      btn_load = 1'b0;
      ticks(N + 4);
      checks++;
      if (changes != 1 || test1 !== a || state_led !== 2'b01) begin
         errors++;
         $display("FAIL long_hold got changes=%0d t1=%b st=%b want changes=1 t1=%b st=01",
                  changes, test1, state_led, a);
      end
      $display("test_long_hold a=%b", a);
   endtask

   task automatic test_reset_mid_debounce();
      logic [1:0] a;
      int lat;
      do_reset();
      press_load(2'b10, 6);
      a = 2'($urandom_range(1, 3));
      sw = a; btn_load = 1'b1;
      ticks(3);
      rst = 1'b1;
      ticks(2);
      checks++;
      if ({test1, test2, operands_valid, state_led} !== 7'b0) begin
         errors++;
         $display("FAIL reset_mid_debounce got t1=%b t2=%b v=%b st=%b want all zero",
                  test1, test2, operands_valid, state_led);
      end
      rst = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (lat == 0 && state_led == 2'b01) lat = k;
      end
      btn_load = 1'b0;
      ticks(N + 4);
      checks++;
      if (lat != N + 3 || test1 !== a) begin
         errors++;
         $display("FAIL post_reset_press got lat=%0d t1=%b want lat=%0d t1=%b", lat, test1, N + 3, a);
      end
      $display("test_reset_mid_debounce a=%b latency=%0d", a, lat);
   endtask

   task automatic test_random();
      int bad;
      int hl, hc;
      do_reset();
      bad = 0; hl = 0; hc = 0;
      for (int k = 0; k < 600; k++) begin
         if (hl == 0) begin btn_load  = 1'($urandom_range(1)); hl = $urandom_range(1, 9); end
         if (hc == 0) begin btn_clear = ($urandom_range(5) == 0); hc = $urandom_range(1, 9); end
         hl--; hc--;
         sw = 2'($urandom_range(3));
         rst = ($urandom_range(199) == 0);
         tick();
         checks++;
         if (test1 !== m_t1 || test2 !== m_t2 || state_led !== m_state ||
             operands_valid !== (m_state == 2'd2)) begin
            errors++; bad++;
            if (bad <= 5)
               $display("FAIL random_cycle_%0d got t1=%b t2=%b st=%b v=%b want t1=%b t2=%b st=%b v=%b",
                        k, test1, test2, state_led, operands_valid,
                        m_t1, m_t2, m_state, (m_state == 2'd2));
         end
      end
      rst = 1'b0; btn_load = 0; btn_clear = 0;
      ticks(N + 4);
      $display("test_random done mismatched_cycles=%0d", bad);
   endtask

   initial begin
      test_reset();
      test_load_sequence();
      test_bounce();
      test_ready_reload();
      test_clear_priority();
      test_long_hold();
      test_reset_mid_debounce();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream front end for the 2-bit ripple adder stage (half_adder + full_adder).
- Turns the board slide switches and two raw push buttons into stable, registered operands test1[1:0] and test2[1:0] that drive the adder inputs directly.
- Contains a synchroniser, a debouncer and rising-edge detector per button, and a 3-state load FSM, so the adder result changes only on deliberate, debounced presses.

Parameters:
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles before a button level change is accepted (1 ms at 100 MHz); legal range ≥2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- sw  input  2  raw slide-switch operand value, asynchronous
- btn_load  input  1  raw load push button, asynchronous, active-high
- btn_clear  input  1  raw clear push button, asynchronous, active-high
- test1  output  2  operand A to adder, registered
- test2  output  2  operand B to adder, registered
- operands_valid  output  1  high while both operands have been loaded (state READY)
- state_led  output  2  FSM state for LEDs: 00 LOAD_A, 01 LOAD_B, 10 READY

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a clk edge):
  - test1=0, test2=0, operands_valid=0, state_led=00, state=LOAD_A.
  - All sync flops, debounced levels, counters and edge registers cleared to 0.
- Synchronisers: sw, btn_load and btn_clear each pass through 2 flops; only synchronised values are used.
- Debounce, per button:
  - Counter resets to 0 on any cycle where synced level == debounced level; otherwise it increments.
  - When the count reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced level takes the synced value and the counter resets.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is never accepted.
- Edge detect: a 1-cycle pulse (load_p / clear_p) on each debounced 0→1 transition; release produces no pulse.
- Latency: with the raw button held high, FSM and output registers update on the edge DEBOUNCE_CYCLES+3 after the first edge that samples it high. Exactly one update per press regardless of hold time.
- FSM, evaluated on pulse cycles only:
  - clear_p, any state: test1=0, test2=0, → LOAD_A.
  - LOAD_A + load_p: test1=synced sw, → LOAD_B.
  - LOAD_B + load_p: test2=synced sw, → READY.
  - READY + load_p: test1=synced sw, test2 holds, → LOAD_B (new sequence).
  - No pulse: all registers hold.
- Priority: clear_p and load_p in the same cycle → clear wins, load ignored. rst overrides everything.
- operands_valid = (state==READY), registered and never glitching. It drops on the same edge as the state leaves READY.
- sw changes alone never alter test1/test2.
- Reset mid-debounce discards the partial count. A button still held after reset is treated as a new press and is accepted DEBOUNCE_CYCLES+3 edges after rst deasserts.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then sw=2'b11, hold btn_load 10 cycles, release; sw=2'b01, press again → after 1st press test1=11, state_led=01; after 2nd test2=01, operands_valid=1, state_led=10; test1 update lands exactly 7 edges after first high sample.
- Bounce btn_load high for 3 cycles / low 1, repeated 5 times, then low → no change; test1=00, state_led=00.
- In READY (test1=11, test2=01), sw=2'b10, press load → test1=10, test2=01, operands_valid=0, state_led=01.
- In LOAD_B with test1=10, raise btn_load and btn_clear on the same cycle for 10 cycles → test1=00, test2=00, state_led=00, no load captured; subsequent load-only press gives test1=sw.
- Hold btn_load 50 cycles → exactly one capture; toggle sw during hold → test1 keeps value sampled at the pulse.
- Assert rst 2 cycles mid-debounce with btn_load still held → outputs 0 during reset; single capture 7 edges after rst deasserts, state_led=01.
